m_dram_store_buffer: RTL and testbench
======================================

# m_dram_store_buffer

Write-side companion to the multi-cycle DRAM instruction/data port. It accepts stores from the pipeline's MA stage in one cycle, queues them in a small FIFO, and drains them one at a time into the slow DRAM using a single-cycle write strobe and an acknowledge pulse. The pipeline stalls only when the buffer is full. Loads are not delayed by queued stores, because the buffer forwards store data to loads that hit a queued address.

## Interface
- DEPTH, 4: number of store entries; must be a power of two, minimum 2.
- D_DELAY, 10: nominal DRAM write latency in cycles. Used only by the bench and by the protocol checker; the RTL is ack-driven.
- w_clock  in  1  rising-edge clock.
- w_reset  in  1  asynchronous, active-high reset.
- w_we  in  1  store request from the MA stage; qualified by !w_full.
- w_addr  in  32  store byte address; word index is w_addr[12:2].
- w_wd  in  32  store data (full word).
- w_full  out  1  combinational; high when count == DEPTH.
- w_empty  out  1  combinational; high when count == 0.
- w_ld_addr  in  32  load address from the MA stage, used for forwarding.
- w_fwd_hit  out  1  combinational; a queued entry matches w_ld_addr[12:2].
- w_fwd_data  out  32  data of the newest matching entry; 0 when there is no hit.
- r_dram_we  out  1  write strobe to DRAM, one cycle wide.
- r_dram_addr  out  32  word-aligned address ({19'b0, idx, 2'b00}).
- r_dram_wd  out  32  write data.
- w_dram_ack  in  1  one-cycle pulse from DRAM when the write has committed.
- r_ovf  out  1  sticky; a store was presented while full.

## Operation
- FIFO of DEPTH entries. Each entry holds an 11-bit word index and 32-bit data. Read and write pointers are log2(DEPTH)+1 bits wide, with wrap-around by natural overflow.
- Push: w_we & !w_full. The entry is written at the write pointer, which then increments.
- Dropped push: w_we & w_full. The store is dropped and r_ovf is set to 1; it stays set until reset.
- Drain FSM, two states:
  - IDLE: if !w_empty, go to WAIT. On that edge, set r_dram_we=1 and load r_dram_addr/r_dram_wd from the head entry.
  - WAIT: r_dram_we is 0 from the second cycle onward. On w_dram_ack, pop the head (read pointer +1) and return to IDLE. The head entry stays in the FIFO, and stays forwardable, until it is acked.
- w_dram_ack received in IDLE is ignored.
- Simultaneous push and ack: count is unchanged and both pointers advance.
- Forwarding:
  - Compare w_ld_addr[12:2] against every valid entry, including the in-flight head.
  - On multiple matches, the entry closest to the write pointer (newest) wins.
  - A push presented in the same cycle is not forwarded.
- Byte offset w_addr[1:0] is ignored. Only word stores are supported.

## Timing
- Reset values:
  - r_dram_we=0, r_dram_addr=0, r_dram_wd=0, r_ovf=0.
  - Pointers 0, state IDLE, so w_empty=1 and w_full=0.
  - w_fwd_hit=0 and w_fwd_data=0 after reset.
- Push at edge N: w_empty falls after edge N, and r_dram_we is high during the cycle after edge N+1 (at the earliest).
- Issue-to-issue spacing is at least 2 cycles plus the DRAM ack latency. With the current DRAM this gives 1 write per D_DELAY+2 cycles.
- w_full changes only on clock edges, through count.
- Reset mid-operation: all state clears immediately, and queued stores are lost. An ack arriving after reset (from a write issued before reset) is ignored, because the FSM is in IDLE.
- Wrap-around: pointers wrap modulo 2*DEPTH. Full/empty are distinguished by the MSB of the pointers.

## Structure
- Shared package holds:
  - the state encoding (IDLE=1'b0, WAIT=1'b1);
  - the DRAM word-index width (11);
  - the default D_DELAY (10), kept equal to the DRAM's `D_DELAY.
- One sub-module, m_sfifo: a parameterised synchronous FIFO with push, pop, head read, and an exposure of the entry array and valid vector for the forwarding search.
- The drain FSM, the forwarding priority search and r_ovf live in the top level.

## Test plan
- Single store: push addr 0x40, data 0xDEADBEEF.
  - -> r_dram_we pulses once, with r_dram_addr=0x40 and r_dram_wd=0xDEADBEEF.
  - -> After ack, w_empty=1 and DRAM mem[16]=0xDEADBEEF.
- Fill: 4 back-to-back pushes (addr 0x0/0x4/0x8/0xC, data 1..4) with no ack.
  - -> w_full=1 after the 4th edge.
  - -> A 5th push sets r_ovf=1; the count stays 4.
- Drain order: ack each write after D_DELAY cycles.
  - -> DRAM writes occur in order with data 1,2,3,4, each r_dram_we exactly one cycle.
  - -> Ends with w_empty=1.
- Forwarding: push 0x80/0x11 then 0x80/0x22, and set w_ld_addr=0x82.
  - -> w_fwd_hit=1, w_fwd_data=0x22.
  - -> After both are acked, w_fwd_hit=0.
- Push and ack in the same cycle while count=4.
  - -> Count stays 4, no r_ovf, and the new entry is drained last.
- Assert w_reset while in WAIT with 3 entries queued, then deliver a late ack.
  - -> All outputs are at reset values, and the late ack causes no pop and no new r_dram_we.

Source files
------------

// File: rtl/m_dram_store_buffer_pkg.sv
// Shared definitions for the DRAM store buffer: drain FSM encoding,
// DRAM word-index width and the nominal DRAM write latency.
package m_dram_store_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } drain_state_t;

  // DRAM word index is addr[12:2]
  localparam int IDX_W = 11;
  localparam int DATA_W = 32;
  localparam int ENTRY_W = IDX_W + DATA_W;

  // Kept equal to the DRAM model's `D_DELAY
  localparam int D_DELAY_DEFAULT = 10;

  // Rebuild a word-aligned byte address from a word index
  function automatic logic [31:0] idx_to_addr(input logic [IDX_W-1:0] idx);
    return {19'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/m_dram_store_buffer_sfifo.sv
// Parameterised synchronous FIFO. Besides push/pop/head it exposes the
// whole entry array, the per-slot valid vector and the read pointer so the
// owner can run an associative search over the queued entries.
module m_sfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_head,
  output logic [DEPTH*WIDTH-1:0] o_entries,
  output logic [DEPTH-1:0]       o_valid,
  output logic [AW-1:0]          o_rd_slot,
  output logic [AW:0]            o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  // Pointers carry one extra MSB so full and empty differ only in that bit
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      w_count;

  assign w_count   = r_wptr - r_rptr;
  assign o_count   = w_count;
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign o_empty   = (w_count == '0);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign o_rd_slot = r_rptr[AW-1:0];

  // A slot is valid when its distance from the read slot is below the count
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] w_rel;
    assign w_rel = AW'(g) - r_rptr[AW-1:0];
    assign o_valid[g] = ({1'b0, w_rel} < w_count);
    assign o_entries[g*WIDTH +: WIDTH] = r_mem[g];
  end

  // Pointer update; wrap-around is by natural overflow of the AW+1 bit counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage needs no reset: contents are only meaningful while valid
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/m_dram_store_buffer.sv
// Store buffer between the MA stage and the slow DRAM write port. Stores
// are queued in one cycle, drained one at a time with a single-cycle write
// strobe and an ack handshake, and forwarded to loads that hit a queued word.
module m_dram_store_buffer
  import m_dram_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int D_DELAY = D_DELAY_DEFAULT
) (
  input  logic        w_clock,
  input  logic        w_reset,
  input  logic        w_we,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_wd,
  output logic        w_full,
  output logic        w_empty,
  input  logic [31:0] w_ld_addr,
  output logic        w_fwd_hit,
  output logic [31:0] w_fwd_data,
  output logic        r_dram_we,
  output logic [31:0] r_dram_addr,
  output logic [31:0] r_dram_wd,
  input  logic        w_dram_ack,
  output logic        r_ovf
);

  localparam int AW = $clog2(DEPTH);

  drain_state_t             r_state;
  logic                     w_push;
  logic                     w_pop;
  logic [ENTRY_W-1:0]       w_head;
  logic [DEPTH*ENTRY_W-1:0] w_entries;
  logic [DEPTH-1:0]         w_valid;
  logic [AW-1:0]            w_rd_slot;
  logic [AW:0]              w_count;
  logic [AW-1:0]            w_slot;
  logic [ENTRY_W-1:0]       w_entry;
  logic                     w_unused;

  // The head is released only when the DRAM confirms the write
  assign w_pop = (r_state == WAIT) && w_dram_ack;

  // A store arriving while full is still taken when the head retires in the
  // same cycle, since a slot frees up on that very edge
  assign w_push = w_we && (!w_full || w_pop);

  assign w_unused = &{1'b0, w_addr[31:13], w_addr[1:0], w_ld_addr[31:13],
                      w_ld_addr[1:0], w_count, D_DELAY[0]};

  m_sfifo #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .i_clk    (w_clock),
    .i_rst    (w_reset),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_wdata  ({w_addr[12:2], w_wd}),
    .o_head   (w_head),
    .o_entries(w_entries),
    .o_valid  (w_valid),
    .o_rd_slot(w_rd_slot),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Drain FSM: issue the head with a one-cycle strobe, then hold until ack
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_state     <= IDLE;
      r_dram_we   <= 1'b0;
      r_dram_addr <= '0;
      r_dram_wd   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dram_we <= 1'b0;
          if (!w_empty) begin
            r_state     <= WAIT;
            r_dram_we   <= 1'b1;
            r_dram_addr <= idx_to_addr(w_head[ENTRY_W-1 -: IDX_W]);
            r_dram_wd   <= w_head[DATA_W-1:0];
          end
        end
        WAIT: begin
          r_dram_we <= 1'b0;
          if (w_dram_ack) r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_dram_we <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a store that found no room and was discarded
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      r_ovf <= 1'b0;
    end else if (w_we && !w_push) begin
      r_ovf <= 1'b1;
    end
  end

  // Walk from oldest to newest so the newest matching entry wins
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_slot     = '0;
    w_entry    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot  = w_rd_slot + AW'(k);
      w_entry = w_entries[w_slot*ENTRY_W +: ENTRY_W];
      if (w_valid[w_slot] && (w_entry[ENTRY_W-1 -: IDX_W] == w_ld_addr[12:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_entry[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_m_dram_store_buffer.sv
// Self-checking bench for m_dram_store_buffer with a small DRAM model that
// logs every write strobe and optionally acks it D_DELAY cycles later.
module tb_m_dram_store_buffer;

  localparam int DEPTH = 4;
  localparam int D_DELAY = 10;

  logic        w_clock = 1'b0;
  logic        w_reset;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wd;
  logic [31:0] w_ld_addr;
  logic        w_full;
  logic        w_empty;
  logic        w_fwd_hit;
  logic [31:0] w_fwd_data;
  logic        r_dram_we;
  logic [31:0] r_dram_addr;
  logic [31:0] r_dram_wd;
  logic        r_ovf;
  logic        ackAuto;
  logic        ackMan;
  logic        autoAck;
  wire         w_dram_ack = ackAuto | ackMan;

  int          total = 0;
  int          bad = 0;
  int          weCycles = 0;
  int          doubleWe = 0;
  logic [31:0] logAddr[$];
  logic [31:0] logData[$];
  logic [31:0] mem [0:2047];

  typedef struct {
    logic        push;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] ld;
    logic        expHit;
    logic [31:0] expData;
    logic        expFull;
  } vec_t;

  vec_t vecs[8];

  m_dram_store_buffer #(
    .DEPTH(DEPTH),
    .D_DELAY(D_DELAY)
  ) dut (
    .w_clock    (w_clock),
    .w_reset    (w_reset),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_wd       (w_wd),
    .w_full     (w_full),
    .w_empty    (w_empty),
    .w_ld_addr  (w_ld_addr),
    .w_fwd_hit  (w_fwd_hit),
    .w_fwd_data (w_fwd_data),
    .r_dram_we  (r_dram_we),
    .r_dram_addr(r_dram_addr),
    .r_dram_wd  (r_dram_wd),
    .w_dram_ack (w_dram_ack),
    .r_ovf      (r_ovf)
  );

  // Free-running clock
  always #5 w_clock = ~w_clock;

  // DRAM model: records each strobe cycle and schedules an ack when enabled
  initial begin : dramModel
    bit pending;
    int cnt;
    bit prevWe;
    pending = 0;
    cnt = 0;
    prevWe = 0;
    ackAuto = 1'b0;
    forever begin
      @(posedge w_clock);
      #1;
      ackAuto = 1'b0;
      if (w_reset) begin
        pending = 0;
        prevWe = 0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            ackAuto = 1'b1;
            pending = 0;
          end
        end
        if (r_dram_we) begin
          if (prevWe) doubleWe++;
          weCycles++;
          logAddr.push_back(r_dram_addr);
          logData.push_back(r_dram_wd);
          mem[r_dram_addr[12:2]] = r_dram_wd;
          if (autoAck) begin
            pending = 1;
            cnt = D_DELAY;
          end
        end
        prevWe = r_dram_we;
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge w_clock);
  endtask

  task automatic applyStimulus(input logic push, input logic [31:0] addr, input logic [31:0] data);
    w_we = push;
    w_addr = addr;
    w_wd = data;
    tick();
    w_we = 1'b0;
  endtask

  task automatic pulseAck();
    ackMan = 1'b1;
    tick();
    ackMan = 1'b0;
  endtask

  task automatic waitEmpty(input int budget, input string name);
    int n = 0;
    while (!w_empty && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, {31'b0, w_empty}, 32'd1);
  endtask

  task automatic doReset();
    w_reset = 1'b1;
    w_we = 1'b0;
    ackMan = 1'b0;
    autoAck = 1'b0;
    w_ld_addr = '0;
    tick();
    tick();
    w_reset = 1'b0;
    logAddr.delete();
    logData.delete();
    weCycles = 0;
    doubleWe = 0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h80,  32'h11, 32'h82,   1'b1, 32'h11, 1'b0};
    vecs[1] = '{1'b1, 32'h80,  32'h22, 32'h80,   1'b1, 32'h22, 1'b0};
    vecs[2] = '{1'b1, 32'h100, 32'h33, 32'h83,   1'b1, 32'h22, 1'b0};
    vecs[3] = '{1'b0, 32'h0,   32'h0,  32'h104,  1'b0, 32'h0,  1'b0};
    vecs[4] = '{1'b1, 32'h104, 32'h44, 32'h104,  1'b1, 32'h44, 1'b1};
    vecs[5] = '{1'b1, 32'h200, 32'h55, 32'h200,  1'b0, 32'h0,  1'b1};
    vecs[6] = '{1'b0, 32'h0,   32'h0,  32'h2080, 1'b1, 32'h22, 1'b1};
    vecs[7] = '{1'b0, 32'h0,   32'h0,  32'h100,  1'b1, 32'h33, 1'b1};

    w_reset = 1'b1;
    w_we = 1'b0;
    w_addr = '0;
    w_wd = '0;
    w_ld_addr = '0;
    ackMan = 1'b0;
    autoAck = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    tick();

    // Reset values
    checkOutput("rst_we",    {31'b0, r_dram_we}, 32'd0);
    checkOutput("rst_addr",  r_dram_addr, 32'd0);
    checkOutput("rst_wd",    r_dram_wd, 32'd0);
    checkOutput("rst_ovf",   {31'b0, r_ovf}, 32'd0);
    checkOutput("rst_empty", {31'b0, w_empty}, 32'd1);
    checkOutput("rst_full",  {31'b0, w_full}, 32'd0);
    checkOutput("rst_hit",   {31'b0, w_fwd_hit}, 32'd0);
    checkOutput("rst_fdata", w_fwd_data, 32'd0);
    doReset();

    // Single store with issue timing
    autoAck = 1'b1;
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF);
    checkOutput("single_empty_n", {31'b0, w_empty}, 32'd0);
    checkOutput("single_we_n",    {31'b0, r_dram_we}, 32'd0);
    tick();
    checkOutput("single_we_n1",   {31'b0, r_dram_we}, 32'd1);
    checkOutput("single_addr",    r_dram_addr, 32'h40);
    checkOutput("single_wd",      r_dram_wd, 32'hDEADBEEF);
    tick();
    checkOutput("single_we_n2",   {31'b0, r_dram_we}, 32'd0);
    waitEmpty(40, "single_drain");
    tick();
    checkOutput("single_count",   logData.size(), 32'd1);
    checkOutput("single_mem",     mem[16], 32'hDEADBEEF);
    checkOutput("single_wecyc",   weCycles, 32'd1);

    // Fill and overflow
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i*4), 32'(i+1));
    checkOutput("fill_full", {31'b0, w_full}, 32'd1);
    checkOutput("fill_ovf0", {31'b0, r_ovf}, 32'd0);
    applyStimulus(1'b1, 32'h10, 32'd5);
    checkOutput("fill_ovf1", {31'b0, r_ovf}, 32'd1);
    checkOutput("fill_full_after", {31'b0, w_full}, 32'd1);

    // Drain order with D_DELAY acks
    autoAck = 1'b1;
    pulseAck();
    waitEmpty(200, "drain_empty");
    tick();
    checkOutput("drain_count", logData.size(), 32'd4);
    for (int i = 0; i < 4 && i < logData.size(); i++) begin
      checkOutput($sformatf("drain_data%0d", i), logData[i], 32'(i+1));
      checkOutput($sformatf("drain_addr%0d", i), logAddr[i], 32'(i*4));
    end
    checkOutput("drain_double", doubleWe, 32'd0);
    checkOutput("drain_wecyc", weCycles, 32'd4);
    checkOutput("drain_ovf_sticky", {31'b0, r_ovf}, 32'd1);

    // Forwarding table
    doReset();
    for (int i = 0; i < 8; i++) begin
      w_ld_addr = vecs[i].ld;
      applyStimulus(vecs[i].push, vecs[i].addr, vecs[i].data);
      checkOutput($sformatf("fwd_hit%0d", i),  {31'b0, w_fwd_hit}, {31'b0, vecs[i].expHit});
      checkOutput($sformatf("fwd_data%0d", i), w_fwd_data, vecs[i].expData);
      checkOutput($sformatf("fwd_full%0d", i), {31'b0, w_full}, {31'b0, vecs[i].expFull});
    end
    w_ld_addr = 32'h82;
    autoAck = 1'b1;
    pulseAck();
    waitEmpty(200, "fwd_drain");
    checkOutput("fwd_hit_after", {31'b0, w_fwd_hit}, 32'd0);
    checkOutput("fwd_data_after", w_fwd_data, 32'd0);

    // Push accepted while full because the head acks in the same cycle
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(32'h10 + i*4), 32'(32'hA1 + i));
    tick();
    ackMan = 1'b1;
    applyStimulus(1'b1, 32'h50, 32'hA5);
    ackMan = 1'b0;
    checkOutput("pa_full", {31'b0, w_full}, 32'd1);
    checkOutput("pa_ovf",  {31'b0, r_ovf}, 32'd0);
    autoAck = 1'b1;
    waitEmpty(300, "pa_drain");
    tick();
    checkOutput("pa_count", logData.size(), 32'd5);
    for (int i = 0; i < 5 && i < logData.size(); i++)
      checkOutput($sformatf("pa_data%0d", i), logData[i], 32'(32'hA1 + i));
    checkOutput("pa_last_addr", mem[20], 32'hA5);

    // Reset while waiting on an ack, then a late ack
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h200 + i*4), 32'(32'hB1 + i));
    tick();
    checkOutput("mr_issued", logData.size(), 32'd1);
    w_ld_addr = 32'h200;
    w_reset = 1'b1;
    tick();
    checkOutput("mr_we",    {31'b0, r_dram_we}, 32'd0);
    checkOutput("mr_addr",  r_dram_addr, 32'd0);
    checkOutput("mr_wd",    r_dram_wd, 32'd0);
    checkOutput("mr_empty", {31'b0, w_empty}, 32'd1);
    checkOutput("mr_hit",   {31'b0, w_fwd_hit}, 32'd0);
    w_reset = 1'b0;
    tick();
    pulseAck();
    tick();
    tick();
    tick();
    checkOutput("mr_late_empty", {31'b0, w_empty}, 32'd1);
    checkOutput("mr_late_full",  {31'b0, w_full}, 32'd0);
    checkOutput("mr_late_we",    weCycles, 32'd1);

    // A push in the same cycle as the load is not forwarded
    doReset();
    w_ld_addr = 32'h300;
    w_we = 1'b1;
    w_addr = 32'h300;
    w_wd = 32'h77;
    #1;
    checkOutput("same_cyc_hit", {31'b0, w_fwd_hit}, 32'd0);
    tick();
    w_we = 1'b0;
    checkOutput("next_cyc_hit",  {31'b0, w_fwd_hit}, 32'd1);
    checkOutput("next_cyc_data", w_fwd_data, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
